instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage upstream of decode (immediate generation, control decode, register read) in the RISC-V core.
- Owns the PC register and issues word requests to instruction memory over a valid/ready request and valid response interface.
- Holds each fetched instruction, with its PC, in an output register for decode, using a valid/ready handshake.
- Accepts redirects (taken branch, JAL, JALR targets) from execute and discards any stale in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset release.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  instruction memory accepts request this cycle.
imem_addr  output  32  fetch address (word aligned).
imem_rsp_valid  input  1  response data valid; arrives at least 1 cycle after acceptance; at most one outstanding.
imem_rdata  input  32  fetched instruction word.
instr_valid  output  1  instr/instr_pc hold a valid instruction.
instr  output  32  registered instruction to decode.
instr_pc  output  32  PC of instr.
instr_ready  input  1  decode consumes instr this cycle.
redirect_valid  input  1  replace PC with redirect_pc.
redirect_pc  input  32  redirect target.
fault  output  1  misaligned redirect flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, immediate):
  - pc=RESET_PC, state=REQ.
  - imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0, fault=0.
  - First request is issued in the first clock after rst_n rises.
- imem_addr = pc at all times; pc[1:0] is always 00.
- Accept = imem_req_valid & imem_req_ready.
- State REQ:
  - imem_req_valid=1.
  - On accept, go to WAIT.
- State WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (wraps modulo 2^32), go to HOLD.
- State HOLD:
  - imem_req_valid=0; instr, instr_pc and instr_valid are held stable.
  - On instr_ready: instr_valid<=0, go to REQ.
- State DRAIN:
  - imem_req_valid=0.
  - Wait for imem_rsp_valid, discard the data, go to REQ. instr_valid stays 0.
- Redirect (redirect_valid=1) overrides all other transitions in the same cycle:
  - pc<=redirect_pc and instr_valid<=0 in every case.
  - REQ without accept: go to REQ; the next cycle's request uses the new PC. The memory must tolerate an address change while imem_req_ready is low.
  - REQ with accept in the same cycle: the fetch is in flight; go to DRAIN.
  - WAIT without imem_rsp_valid: go to DRAIN.
  - WAIT with imem_rsp_valid in the same cycle: discard the data, go to REQ.
  - HOLD: the held instruction counts as consumed (instr_ready is don't-care); go to REQ.
  - DRAIN: update pc and stay in DRAIN. If imem_rsp_valid arrives in the same cycle, go to REQ.
- Timing:
  - Minimum fetch-to-valid latency: 2 cycles from request assertion with zero-wait memory (REQ, WAIT, then valid).
  - Throughput: at most one instruction per 3 cycles.
- imem_rsp_valid in REQ or HOLD is ignored; this is an assertion target for the bench.

Optional Feature:
- Macro IFU_MISALIGN_CHK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=00 sets fault=1 (sticky until reset) and enters a terminal HALT state.
  - In HALT: imem_req_valid=0, instr_valid=0, and any outstanding response is ignored.
  - pc captures redirect_pc unmodified for debug.
- Undefined:
  - redirect_pc[1:0] is ignored; pc<={redirect_pc[31:2],2'b00}.
  - fault is tied to 0 and there is no HALT state.

Test Plan:
1. RESET_PC=0x0000_1000; memory ready always, 1-cycle response 0x00500093 -> imem_addr=0x1000; instr_valid=1 with instr=0x00500093 and instr_pc=0x1000; after instr_ready, next request at 0x1004.
2. instr_ready held low 5 cycles after a fetch -> instr/instr_pc stable; imem_req_valid=0 throughout; request at pc+4 the cycle after instr_ready=1.
3. Redirect to 0x2000 in WAIT; stale response 0xDEADBEEF two cycles later -> discarded; instr_valid stays 0; next request at 0x2000.
4. Redirect to 0x3000 in the same cycle as imem_rsp_valid -> data dropped; request at 0x3000 the next cycle; no DRAIN cycle.
5. rst_n low mid-WAIT -> imem_req_valid=0 and instr_valid=0 immediately (asynchronous); after release, fetch restarts at RESET_PC; a late response during REQ is ignored.
6. Redirect to 0x2002 -> with IFU_MISALIGN_CHK_EN: fault=1 and no further requests for 20 cycles; without the macro: fault=0 and request at 0x2000.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response and the
// decode-side instruction handshake. The fetch unit uses the master side.
interface instr_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rdata, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time to
// instruction memory and holds the fetched word for decode. Redirects from
// execute replace the PC and discard any stale in-flight fetch.
// Optional macro IFU_MISALIGN_CHK_EN: misaligned redirects raise a sticky
// fault and park the unit in a terminal HALT state.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instr_fetch_unit_if.master         bus,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       fault
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
`ifdef IFU_MISALIGN_CHK_EN
    , S_HALT
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;
  logic        accept;
  logic        halted;
  logic        misaligned;

`ifdef IFU_MISALIGN_CHK_EN
  logic        fault_q, fault_d;
  assign halted     = (state_q == S_HALT);
  assign misaligned = |redirect_pc[1:0];
  assign fault      = fault_q;
`else
  logic        fault_q, fault_d;
  logic [1:0]  unused_rpc_lo;
  assign unused_rpc_lo = redirect_pc[1:0];
  assign halted     = 1'b0;
  assign misaligned = 1'b0;
  assign fault      = 1'b0;
`endif

  // Request valid is registered so nothing is requested while in reset;
  // it simply tracks "next state is REQ".
  assign accept             = req_q & bus.imem_req_ready;
  assign bus.imem_req_valid = req_q;
  assign bus.imem_addr      = pc_q;
  assign bus.instr_valid    = valid_q;
  assign bus.instr          = instr_q;
  assign bus.instr_pc       = instr_pc_q;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
      fault_q    <= fault_d;
    end
  end

  // Next-state logic: normal fetch sequencing, then redirect override.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    fault_d    = fault_q;

    case (state_q)
      S_REQ:   if (accept) state_d = S_WAIT;
      S_WAIT:  if (bus.imem_rsp_valid) begin
                 instr_d    = bus.imem_rdata;
                 instr_pc_d = pc_q;
                 valid_d    = 1'b1;
                 pc_d       = pc_q + 32'd4;
                 state_d    = S_HOLD;
               end
      S_HOLD:  if (bus.instr_ready) begin
                 valid_d = 1'b0;
                 state_d = S_REQ;
               end
      S_DRAIN: if (bus.imem_rsp_valid) state_d = S_REQ;
      default: ;
    endcase

    if (redirect_valid && !halted) begin
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = 1'b0;
      pc_d       = {redirect_pc[31:2], 2'b00};
      case (state_q)
        S_REQ:   state_d = accept ? S_DRAIN : S_REQ;
        S_WAIT:  state_d = bus.imem_rsp_valid ? S_REQ : S_DRAIN;
        S_HOLD:  state_d = S_REQ;
        S_DRAIN: state_d = bus.imem_rsp_valid ? S_REQ : S_DRAIN;
        default: ;
      endcase
`ifdef IFU_MISALIGN_CHK_EN
      if (misaligned) begin
        pc_d    = redirect_pc;
        fault_d = 1'b1;
        state_d = S_HALT;
      end
`endif
    end

    req_d = (state_d == S_REQ);
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed sequences, a table of
// redirect/fetch vectors, and a randomized run against a transaction-level
// model (expected fetch address stream, outstanding fetch, held instruction).
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  instr_fetch_unit_if ifc ();

  instr_fetch_unit #(.RESET_PC(32'h0000_1000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (ifc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] target;
    logic [31:0] word;
    logic [31:0] exp_pc;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[$];

  // Random-run reference model state.
  logic [31:0] m_exp_addr, m_out_pc, m_held_pc, m_target;
  logic        m_out, m_live, m_held, m_rsp, m_redir, m_ready, m_iready;
  logic        s_req, s_accept;
  logic [31:0] s_addr;
  int unsigned m_delay, idle;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_req(input string nm, input logic [31:0] exp_addr);
    int unsigned n = 0;
    while (ifc.imem_req_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, " req_valid"}, {31'd0, ifc.imem_req_valid}, 32'd1);
    check({nm, " imem_addr"}, ifc.imem_addr, exp_addr);
  endtask

  task automatic do_fetch(input string nm, input logic [31:0] exp_addr, input logic [31:0] data);
    ifc.imem_req_ready = 1'b1;
    wait_req(nm, exp_addr);
    @(negedge clk);
    check({nm, " wait req_valid"}, {31'd0, ifc.imem_req_valid}, 32'd0);
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rdata     = data;
    @(negedge clk);
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rdata     = $urandom;
    check({nm, " instr_valid"}, {31'd0, ifc.instr_valid}, 32'd1);
    check({nm, " instr"}, ifc.instr, data);
    check({nm, " instr_pc"}, ifc.instr_pc, exp_addr);
  endtask

  task automatic consume();
    ifc.instr_ready = 1'b1;
    @(negedge clk);
    ifc.instr_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    ifc.imem_req_ready = 1'b1;
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rdata     = '0;
    ifc.instr_ready    = 1'b0;

    vecs.push_back('{32'h0000_4000, 32'h0000_0013, 32'h0000_4000, 32'h0000_4004});
    vecs.push_back('{32'h0000_0000, 32'h0010_0093, 32'h0000_0000, 32'h0000_0004});
    vecs.push_back('{32'hFFFF_FFFC, 32'hFFF0_0113, 32'hFFFF_FFFC, 32'h0000_0000});
    vecs.push_back('{32'h8000_0000, 32'h0041_8193, 32'h8000_0000, 32'h8000_0004});
`ifndef IFU_MISALIGN_CHK_EN
    vecs.push_back('{32'h0000_5003, 32'h0052_8213, 32'h0000_5000, 32'h0000_5004});
`endif

    repeat (3) @(negedge clk);
    check("reset req_valid", {31'd0, ifc.imem_req_valid}, 32'd0);
    check("reset instr_valid", {31'd0, ifc.instr_valid}, 32'd0);
    check("reset instr", ifc.instr, 32'd0);
    check("reset instr_pc", ifc.instr_pc, 32'd0);
    check("reset fault", {31'd0, fault}, 32'd0);
    check("reset imem_addr", ifc.imem_addr, 32'h0000_1000);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: first fetch from RESET_PC
    do_fetch("t1", 32'h0000_1000, 32'h0050_0093);
    consume();
    check("t1 next req_valid", {31'd0, ifc.imem_req_valid}, 32'd1);
    check("t1 next addr", ifc.imem_addr, 32'h0000_1004);

    // 2: decode stalls for 5 cycles
    do_fetch("t2", 32'h0000_1004, 32'h0020_8133);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2 hold instr", ifc.instr, 32'h0020_8133);
      check("t2 hold instr_pc", ifc.instr_pc, 32'h0000_1004);
      check("t2 hold valid", {31'd0, ifc.instr_valid}, 32'd1);
      check("t2 hold req_valid", {31'd0, ifc.imem_req_valid}, 32'd0);
    end
    consume();
    check("t2 after valid", {31'd0, ifc.instr_valid}, 32'd0);
    check("t2 after req_valid", {31'd0, ifc.imem_req_valid}, 32'd1);
    check("t2 after addr", ifc.imem_addr, 32'h0000_1008);

    // 3: redirect in WAIT, stale response two cycles later
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t3 drain valid", {31'd0, ifc.instr_valid}, 32'd0);
    check("t3 drain req_valid", {31'd0, ifc.imem_req_valid}, 32'd0);
    @(negedge clk);
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rdata     = 32'hDEAD_BEEF;
    @(negedge clk);
    ifc.imem_rsp_valid = 1'b0;
    check("t3 stale valid", {31'd0, ifc.instr_valid}, 32'd0);
    check("t3 req_valid", {31'd0, ifc.imem_req_valid}, 32'd1);
    check("t3 addr", ifc.imem_addr, 32'h0000_2000);
    do_fetch("t3", 32'h0000_2000, 32'h0010_0113);
    consume();

    // 4: redirect coincident with response, no drain cycle
    check("t4 addr", ifc.imem_addr, 32'h0000_2004);
    @(negedge clk);
    redirect_valid     = 1'b1;
    redirect_pc        = 32'h0000_3000;
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rdata     = 32'h0BAD_0BAD;
    @(negedge clk);
    redirect_valid     = 1'b0;
    ifc.imem_rsp_valid = 1'b0;
    check("t4 valid", {31'd0, ifc.instr_valid}, 32'd0);
    check("t4 req_valid", {31'd0, ifc.imem_req_valid}, 32'd1);
    check("t4 addr new", ifc.imem_addr, 32'h0000_3000);
    do_fetch("t4", 32'h0000_3000, 32'h0030_0193);
    consume();

    // 5: asynchronous reset mid-WAIT, late response in REQ
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5 async req_valid", {31'd0, ifc.imem_req_valid}, 32'd0);
    check("t5 async instr_valid", {31'd0, ifc.instr_valid}, 32'd0);
    check("t5 async addr", ifc.imem_addr, 32'h0000_1000);
    check("t5 async instr", ifc.instr, 32'd0);
    repeat (2) @(negedge clk);
    ifc.imem_req_ready = 1'b0;
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rdata     = 32'h0BAD_F00D;
    rst_n              = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ifc.imem_rsp_valid = 1'b0;
    check("t5 late valid", {31'd0, ifc.instr_valid}, 32'd0);
    check("t5 req_valid", {31'd0, ifc.imem_req_valid}, 32'd1);
    check("t5 addr", ifc.imem_addr, 32'h0000_1000);
    do_fetch("t5", 32'h0000_1000, 32'h00A0_0193);
    consume();
    ifc.imem_req_ready = 1'b0;

    // 6: misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2002;
    @(negedge clk);
    redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
    check("t6 fault", {31'd0, fault}, 32'd1);
    ifc.imem_req_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("t6 halt req_valid", {31'd0, ifc.imem_req_valid}, 32'd0);
      check("t6 halt instr_valid", {31'd0, ifc.instr_valid}, 32'd0);
      @(negedge clk);
    end
    check("t6 fault sticky", {31'd0, fault}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6 fault cleared", {31'd0, fault}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
`else
    check("t6 fault", {31'd0, fault}, 32'd0);
    check("t6 req_valid", {31'd0, ifc.imem_req_valid}, 32'd1);
    check("t6 addr", ifc.imem_addr, 32'h0000_2000);
`endif
    ifc.imem_req_ready = 1'b0;
    @(negedge clk);

    // Table: redirect in REQ (no accept), fetch target, check successor PC
    for (int i = 0; i < vecs.size(); i++) begin
      redirect_valid = 1'b1;
      redirect_pc    = vecs[i].target;
      @(negedge clk);
      redirect_valid = 1'b0;
      check("tbl redirect addr", ifc.imem_addr, vecs[i].exp_pc);
      do_fetch("tbl", vecs[i].exp_pc, vecs[i].word);
      ifc.imem_req_ready = 1'b0;
      consume();
      check("tbl next valid", {31'd0, ifc.instr_valid}, 32'd0);
      check("tbl next req_valid", {31'd0, ifc.imem_req_valid}, 32'd1);
      check("tbl next addr", ifc.imem_addr, vecs[i].exp_next);
    end

    // Randomized run against the transaction model
    ifc.imem_req_ready = 1'b0;
    do_reset();
    m_exp_addr = 32'h0000_1000;
    m_out      = 1'b0;
    m_live     = 1'b0;
    m_held     = 1'b0;
    m_out_pc   = '0;
    m_held_pc  = '0;
    m_delay    = 0;
    idle       = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      s_req  = ifc.imem_req_valid;
      s_addr = ifc.imem_addr;
      check("rnd instr_valid", {31'd0, ifc.instr_valid}, {31'd0, m_held});
      if (m_held) begin
        check("rnd instr_pc", ifc.instr_pc, m_held_pc);
        check("rnd instr", ifc.instr, memword(m_held_pc));
      end
      if (s_req) begin
        check("rnd req addr", s_addr, m_exp_addr);
        check("rnd req while busy", {31'd0, m_out | m_held}, 32'd0);
      end
      check("rnd fault", {31'd0, fault}, 32'd0);
      if (idle > 40) begin
        check("rnd progress", idle, 32'd0);
        idle = 0;
      end

      m_ready  = ($urandom % 4) != 0;
      m_iready = ($urandom % 2) != 0;
      m_redir  = ($urandom % 10) == 0;
      m_target = {$urandom, 2'b00};
      m_rsp    = m_out && (m_delay == 0);
      ifc.imem_req_ready = m_ready;
      ifc.instr_ready    = m_iready;
      redirect_valid     = m_redir;
      redirect_pc        = m_target;
      if (m_rsp) begin
        ifc.imem_rsp_valid = 1'b1;
        ifc.imem_rdata     = memword(m_out_pc);
      end else begin
        ifc.imem_rsp_valid = (!m_out) && (($urandom % 8) == 0);
        ifc.imem_rdata     = $urandom;
      end

      s_accept = s_req && m_ready;
      idle++;
      if (m_held && m_iready) begin
        m_held = 1'b0;
        idle   = 0;
      end
      if (m_rsp) begin
        m_out = 1'b0;
        if (m_live && !m_redir) begin
          m_held    = 1'b1;
          m_held_pc = m_out_pc;
        end
      end else if (m_out) begin
        m_delay--;
      end
      if (s_accept) begin
        m_out      = 1'b1;
        m_live     = 1'b1;
        m_out_pc   = s_addr;
        m_delay    = $urandom_range(0, 2);
        m_exp_addr = s_addr + 32'd4;
        idle       = 0;
      end
      if (m_redir) begin
        m_exp_addr = m_target;
        m_live     = 1'b0;
        m_held     = 1'b0;
      end
    end
    @(negedge clk);
    redirect_valid     = 1'b0;
    ifc.imem_rsp_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
